decoder_nto2n_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable, optional active-low outputs and a built-in auto-scan mode. In direct mode it decodes `sel` onto `out`. In scan mode it steps the active output through all 2^N positions at a programmable rate. It sits between board-level select logic and multiplexed outputs such as digit anodes or LED rows, replacing the fixed 2-to-4 and 3-to-8 combinational decoders.

---
 rtl/decoder_nto2n_scan_pkg.sv | 35 +++
 rtl/decoder_nto2n_scan_if.sv | 37 +++
 rtl/decoder_nto2n_scan_tick_gen.sv | 39 +++
 rtl/decoder_nto2n_scan.sv | 97 +++++++++
 tb/tb_decoder_nto2n_scan.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/decoder_nto2n_scan_pkg.sv
// Shared types and helpers for the N-to-2^N scanning decoder.
//   state_t  : FSM states (IDLE, DIRECT, SCAN)
//   mode_t   : decoded meaning of the mode input
//   onehot() : index -> one-hot vector, masked to 2^n outputs
//   MAX_N    : largest supported select width
package decoder_pkg;

    localparam int unsigned MAX_N    = 6;
    localparam int unsigned MAX_OUTS = 2 ** MAX_N;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    typedef enum logic {
        MODE_DIRECT,
        MODE_SCAN
    } mode_t;

    // Result is MAX_OUTS wide; callers size-cast down to their own 2^N outputs.
    function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] idx,
                                                   input int unsigned     n);
        logic [MAX_OUTS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_OUTS; i++) begin
            if ((i < (32'd1 << n)) && (32'(idx) == i)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_nto2n_scan_if.sv
// Bus between select logic (master) and the scanning decoder (slave).
//   en   : enable, low forces outputs inactive
//   mode : 0 direct decode, 1 auto-scan
//   sel  : direct index / scan start index
//   out  : registered one-hot (or one-cold) outputs
//   idx  : index currently shown on out
//   wrap : one-cycle pulse when the scan steps from the last index to 0
interface decoder_nto2n_scan_if #(
    parameter int unsigned N = 3
) ();

    logic              en;
    logic              mode;
    logic [N-1:0]      sel;
    logic [2**N-1:0]   out;
    logic [N-1:0]      idx;
    logic              wrap;

    modport master (
        output en,
        output mode,
        output sel,
        input  out,
        input  idx,
        input  wrap
    );

    modport slave (
        input  en,
        input  mode,
        input  sel,
        output out,
        output idx,
        output wrap
    );

endinterface

// File: rtl/decoder_nto2n_scan_tick_gen.sv
// Scan-rate prescaler.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear; holds the count at 0 and suppresses tick
//   tick : one-cycle pulse every TICK_DIV clocks while clr is low
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = !clr && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == Last)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N decoder with enable, optional active-low outputs and auto-scan.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   bus.en     : enable
//   bus.mode   : 0 direct, 1 scan
//   bus.sel    : direct index / scan start index
//   bus.out    : registered one-hot (one-cold when ACTIVE_LOW)
//   bus.idx    : index currently driven on out
//   bus.wrap   : pulse in the cycle out first shows index 0 after a scan wrap
module decoder_nto2n_scan
    import decoder_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned TICK_DIV   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_nto2n_scan_if.slave  bus
);

    localparam int unsigned     Outs     = 2 ** N;
    localparam logic [Outs-1:0] Inactive = {Outs{ACTIVE_LOW}};
    localparam logic [N-1:0]    IdxMax   = '1;

    state_t          state_q, state_d;
    logic [N-1:0]    idx_q;
    logic [N-1:0]    idx_inc;
    logic [Outs-1:0] out_q;
    logic [Outs-1:0] oh_sel;
    logic [Outs-1:0] oh_inc;
    logic            wrap_q;
    logic            scan_run;
    logic            step;

    always_comb begin
        state_d = IDLE;
        if (bus.en) begin
            state_d = (mode_t'(bus.mode) == MODE_SCAN) ? SCAN : DIRECT;
        end
    end

    // Prescaler only runs while staying in SCAN; entry cycles and other states clear it.
    assign scan_run = (state_q == SCAN) && (state_d == SCAN);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (!scan_run),
        .tick (step)
    );

    assign idx_inc = idx_q + N'(1);
    assign oh_sel  = Outs'(onehot(MAX_N'(bus.sel), N)) ^ Inactive;
    assign oh_inc  = Outs'(onehot(MAX_N'(idx_inc), N)) ^ Inactive;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= Inactive;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= 1'b0;
            case (state_d)
                IDLE: begin
                    out_q <= Inactive;
                end
                DIRECT: begin
                    idx_q <= bus.sel;
                    out_q <= oh_sel;
                end
                SCAN: begin
                    if (state_q != SCAN) begin
                        idx_q <= bus.sel;
                        out_q <= oh_sel;
                    end else if (step) begin
                        idx_q  <= idx_inc;
                        out_q  <= oh_inc;
                        wrap_q <= (idx_q == IdxMax);
                    end
                end
                default: begin
                    out_q <= Inactive;
                end
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Three decoder builds driven side by side from one stimulus stream and compared against
// an arithmetic model: scan position = start + (cycles since entry) / TICK_DIV.
//   unit 0: N=3 TICK_DIV=4 active-high
//   unit 1: N=2 TICK_DIV=3 active-low
//   unit 2: N=1 TICK_DIV=1 active-high
module tb_decoder_nto2n_scan;

    logic clk;
    logic rst;

    decoder_nto2n_scan_if #(.N(3)) if_a ();
    decoder_nto2n_scan_if #(.N(2)) if_b ();
    decoder_nto2n_scan_if #(.N(1)) if_c ();

    decoder_nto2n_scan #(.N(3), .TICK_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );
    decoder_nto2n_scan #(.N(2), .TICK_DIV(3), .ACTIVE_LOW(1'b1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );
    decoder_nto2n_scan #(.N(1), .TICK_DIV(1), .ACTIVE_LOW(1'b0)) u_dut_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned m_n  [3] = '{3, 2, 1};
    int unsigned m_td [3] = '{4, 3, 1};
    bit          m_al [3] = '{1'b0, 1'b1, 1'b0};

    bit          m_scan  [3];
    int unsigned m_start [3];
    int unsigned m_k     [3];
    int unsigned m_idx   [3];
    logic [63:0] m_out   [3];
    bit          m_wrap  [3];

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "reset";

    bit          cur_en;
    bit          cur_mode;
    logic [31:0] cur_sel;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pattern(input int u, input bit active, input int unsigned i);
        logic [63:0] p;
        p = active ? (64'd1 << i) : 64'd0;
        if (m_al[u]) p = p ^ ((64'd1 << (32'd1 << m_n[u])) - 64'd1);
        return p;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_scan[u] = 1'b0;
            m_k[u]    = 0;
            m_idx[u]  = 0;
            m_out[u]  = pattern(u, 1'b0, 0);
            m_wrap[u] = 1'b0;
        end
    endtask

    // Effect of one rising edge with the given inputs.
    task automatic model_step(input bit en, input bit mode, input logic [31:0] sel_raw);
        for (int u = 0; u < 3; u++) begin
            int unsigned size;
            int unsigned sel;
            size      = 32'd1 << m_n[u];
            sel       = sel_raw % size;
            m_wrap[u] = 1'b0;
            if (!en) begin
                m_scan[u] = 1'b0;
                m_out[u]  = pattern(u, 1'b0, 0);
            end else if (!mode) begin
                m_scan[u] = 1'b0;
                m_idx[u]  = sel;
                m_out[u]  = pattern(u, 1'b1, sel);
            end else begin
                if (!m_scan[u]) begin
                    m_scan[u]  = 1'b1;
                    m_start[u] = sel;
                    m_k[u]     = 0;
                end else begin
                    m_k[u]++;
                end
                m_idx[u]  = (m_start[u] + m_k[u] / m_td[u]) % size;
                m_out[u]  = pattern(u, 1'b1, m_idx[u]);
                m_wrap[u] = (m_k[u] > 0) && (m_k[u] % m_td[u] == 0) && (m_idx[u] == 0);
            end
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 3; u++) begin
            logic [63:0] go;
            logic [63:0] gi;
            logic [63:0] gw;
            case (u)
                0:       begin go = 64'(if_a.out); gi = 64'(if_a.idx); gw = 64'(if_a.wrap); end
                1:       begin go = 64'(if_b.out); gi = 64'(if_b.idx); gw = 64'(if_b.wrap); end
                default: begin go = 64'(if_c.out); gi = 64'(if_c.idx); gw = 64'(if_c.wrap); end
            endcase
            check_eq($sformatf("%s/u%0d/out", phase, u), go, m_out[u]);
            check_eq($sformatf("%s/u%0d/idx", phase, u), gi, 64'(m_idx[u]));
            check_eq($sformatf("%s/u%0d/wrap", phase, u), gw, 64'(m_wrap[u]));
        end
    endtask

    task automatic drive(input bit en, input bit mode, input logic [31:0] sel_r);
        cur_en   = en;
        cur_mode = mode;
        cur_sel  = sel_r;
        if_a.en  = en;  if_a.mode = mode;  if_a.sel = sel_r[2:0];
        if_b.en  = en;  if_b.mode = mode;  if_b.sel = sel_r[1:0];
        if_c.en  = en;  if_c.mode = mode;  if_c.sel = sel_r[0];
        model_step(en, mode, sel_r);
    endtask

    task automatic cycle(input bit en, input bit mode, input logic [31:0] sel_r);
        @(negedge clk);
        check_all();
        drive(en, mode, sel_r);
    endtask

    // Reset pulsed between edges: outputs must clear at once, then scan restarts from sel.
    task automatic mid_reset(input bit en, input bit mode, input logic [31:0] sel_r);
        @(negedge clk);
        check_all();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        drive(en, mode, sel_r);
    endtask

    initial begin
        rst = 1'b1;
        if_a.en = 1'b0; if_a.mode = 1'b0; if_a.sel = '0;
        if_b.en = 1'b0; if_b.mode = 1'b0; if_b.sel = '0;
        if_c.en = 1'b0; if_c.mode = 1'b0; if_c.sel = '0;
        cur_en = 1'b0; cur_mode = 1'b0; cur_sel = '0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0);

        phase = "sweep";
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'(i));

        phase = "disable";
        cycle(1'b1, 1'b0, 32'd2);
        cycle(1'b0, 1'b0, 32'd2);
        cycle(1'b0, 1'b0, 32'd2);

        phase = "scan";
        cycle(1'b1, 1'b0, 32'd1);
        cycle(1'b1, 1'b1, 32'd1);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, $urandom);

        phase = "modesw";
        cycle(1'b1, 1'b0, 32'd2);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'd2);

        phase = "rescan";
        cycle(1'b1, 1'b1, 32'd5);
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b1, $urandom);
        phase = "asyncrst";
        mid_reset(1'b1, 1'b1, 32'd3);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, $urandom);

        phase = "random";
        for (int i = 0; i < 2500; i++) begin
            bit          en;
            bit          mode;
            logic [31:0] s;
            en   = cur_en;
            mode = cur_mode;
            if ($urandom_range(24, 0) == 0) en = !en;
            if ($urandom_range(14, 0) == 0) mode = !mode;
            s = $urandom;
            if ($urandom_range(299, 0) == 0) mid_reset(en, mode, s);
            else cycle(en, mode, s);
        end

        @(negedge clk);
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
